// File: rtl/mxu_pkg.sv
// Shared constants and FSM encoding for the matrix-multiplier sequencer.
package mxu_pkg;

  localparam int MAT_W  = 256;
  localparam int ELEM_W = 16;
  localparam int DIM    = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin arbiter: on a tie, grants the requester not granted last.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant_onehot
);

  // i_last = index of the most recent winner
  assign o_grant_onehot[0] = i_req[0] & (~i_req[1] | i_last);
  assign o_grant_onehot[1] = i_req[1] & (~i_req[0] | ~i_last);

endmodule

// File: rtl/matrix_unit_ctrl.sv
// Sequencer/arbiter sharing one 4x4x16 matrix multiplier between two requesters.
// Optional MXU_CTRL_PERF_EN adds saturating op_count / busy_cycles counters.
module matrix_unit_ctrl
  import mxu_pkg::*;
#(
  parameter int MM_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [MAT_W-1:0] op_a0,
  input  logic [MAT_W-1:0] op_a1,
  input  logic [MAT_W-1:0] op_b0,
  input  logic [MAT_W-1:0] op_b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [MAT_W-1:0] result,
  output logic             busy,
  output logic             mm_enable,
  output logic [MAT_W-1:0] mm_m1,
  output logic [MAT_W-1:0] mm_m2,
  input  logic [MAT_W-1:0] mm_result
`ifdef MXU_CTRL_PERF_EN
  ,
  output logic [31:0]      op_count,
  output logic [31:0]      busy_cycles
`endif
);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_last;
  logic               r_owner;
  logic [MAT_W-1:0]   r_m1;
  logic [MAT_W-1:0]   r_m2;
  logic [MAT_W-1:0]   r_result;
  logic [1:0]         w_grant;
  logic               w_cnt_last;

  rr_arb2 u_arb (
    .i_req          ({req1, req0}),
    .i_last         (r_last),
    .o_grant_onehot (w_grant)
  );

  assign w_cnt_last = (r_cnt == CNT_W'(MM_LATENCY - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (|w_grant) w_state_next = RUN;
      RUN:     if (w_cnt_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operands are captured only at grant so mm_m1/mm_m2 stay frozen for the whole RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_m1     <= '0;
      r_m2     <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_owner <= w_grant[1];
            r_last  <= w_grant[1];
            r_m1    <= w_grant[1] ? op_a1 : op_a0;
            r_m2    <= w_grant[1] ? op_b1 : op_b0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_cnt_last) r_result <= mm_result;
        end
        default: ;
      endcase
    end
  end

  // Grant is the first RUN cycle; r_cnt is zero only there
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    busy      = 1'b0;
    mm_enable = 1'b0;
    case (r_state)
      RUN: begin
        mm_enable = 1'b1;
        busy      = 1'b1;
        gnt0      = (r_cnt == '0) & ~r_owner;
        gnt1      = (r_cnt == '0) &  r_owner;
      end
      DONE: begin
        busy  = 1'b1;
        done0 = ~r_owner;
        done1 =  r_owner;
      end
      default: ;
    endcase
  end

  assign result = r_result;
  assign mm_m1  = r_m1;
  assign mm_m2  = r_m2;

`ifdef MXU_CTRL_PERF_EN
  logic [31:0] r_op_count;
  logic [31:0] r_busy_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_count    <= '0;
      r_busy_cycles <= '0;
    end else begin
      if ((r_state == DONE) && (r_op_count != 32'hFFFF_FFFF))
        r_op_count <= r_op_count + 32'd1;
      if (busy && (r_busy_cycles != 32'hFFFF_FFFF))
        r_busy_cycles <= r_busy_cycles + 32'd1;
    end
  end

  assign op_count    = r_op_count;
  assign busy_cycles = r_busy_cycles;
`endif

endmodule

// File: tb/tb_matrix_unit_ctrl.sv
// Directed scoreboard bench for matrix_unit_ctrl with a golden 4x4x16 multiplier stub.
module tb_matrix_unit_ctrl;
  import mxu_pkg::*;

`ifdef MXU_CTRL_PERF_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic             clk;
  logic             reset;
  logic             req0, req1;
  logic [MAT_W-1:0] op_a0, op_a1, op_b0, op_b1;
  logic             gnt0, gnt1, done0, done1, busy, mm_enable;
  logic [MAT_W-1:0] result, mm_m1, mm_m2, mm_result;
`ifdef MXU_CTRL_PERF_EN
  logic [31:0]      op_count, busy_cycles;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int               sb_who[$];
  logic [MAT_W-1:0] sb_res[$];

  matrix_unit_ctrl #(.MM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .op_a0(op_a0), .op_a1(op_a1), .op_b0(op_b0), .op_b1(op_b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy), .mm_enable(mm_enable),
    .mm_m1(mm_m1), .mm_m2(mm_m2), .mm_result(mm_result)
`ifdef MXU_CTRL_PERF_EN
    , .op_count(op_count), .busy_cycles(busy_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element [r][c] lives at bits c*16 + r*64; products truncate to 16 bits
  function automatic logic [MAT_W-1:0] matmul(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
    logic [MAT_W-1:0] c;
    logic [15:0] acc;
    c = '0;
    for (int r = 0; r < DIM; r++)
      for (int cc = 0; cc < DIM; cc++) begin
        acc = '0;
        for (int k = 0; k < DIM; k++)
          acc = acc + 16'(a[k*16 + r*64 +: 16] * b[cc*16 + k*64 +: 16]);
        c[cc*16 + r*64 +: 16] = acc;
      end
    return c;
  endfunction

  always_comb mm_result = matmul(mm_m1, mm_m2);

  task automatic check(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int who, input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
    if (who == 0) begin op_a0 = a; op_b0 = b; req0 = 1'b1; end
    else          begin op_a1 = a; op_b1 = b; req1 = 1'b1; end
    sb_who.push_back(who);
    sb_res.push_back(matmul(a, b));
    $display("issue req%0d", who);
  endtask

  task automatic wait_gnt(input int who, input int exp_lat);
    int n;
    logic g;
    n = 0;
    do begin
      tick();
      n++;
      g = (who == 0) ? gnt0 : gnt1;
      check("gnt_exclusive", gnt0 & gnt1, 0);
      if (!g) check("enable_low_waiting", mm_enable, 0);
    end while (!g && n < 40);
    check($sformatf("gnt%0d_latency", who), n, exp_lat);
    check("gnt_other_low", (who == 0) ? gnt1 : gnt0, 0);
    check("enable_at_gnt", mm_enable, 1);
    check("busy_at_gnt", busy, 1);
    check("mm_m1_operand", mm_m1, (who == 0) ? op_a0 : op_a1);
    check("mm_m2_operand", mm_m2, (who == 0) ? op_b0 : op_b1);
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    $display("gnt%0d after %0d cycles", who, n);
  endtask

  task automatic wait_done(input int exp_lat);
    int n;
    int who;
    logic [MAT_W-1:0] exp_res;
    n = 0;
    do begin
      tick();
      n++;
      check("done_exclusive", done0 & done1, 0);
      if (!(done0 | done1)) begin
        check("enable_in_run", mm_enable, 1);
        check("no_gnt_in_run", gnt0 | gnt1, 0);
      end
    end while (!(done0 | done1) && n < 40);
    check("done_latency", n, exp_lat);
    if (sb_who.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      who = sb_who.pop_front();
      exp_res = sb_res.pop_front();
      check($sformatf("done%0d_owner", who), (who == 0) ? done0 : done1, 1);
      check("result", result, exp_res);
      $display("done%0d result=%0h", who, result);
    end
    check("enable_low_done", mm_enable, 0);
    check("busy_in_done", busy, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_gnt", {gnt0, gnt1}, 0);
    check("rst_done", {done0, done1}, 0);
    check("rst_busy_en", {busy, mm_enable}, 0);
    check("rst_result", result, 0);
    check("rst_mm_m1", mm_m1, 0);
    check("rst_mm_m2", mm_m2, 0);
    $display("reset done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    logic [MAT_W-1:0] ident, seq, k100, ma, mb, mc, md;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    op_a0 = '0; op_a1 = '0; op_b0 = '0; op_b1 = '0;
    ident = '0; seq = '0; k100 = '0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        ident[c*16 + r*64 +: 16] = (r == c) ? 16'd1 : 16'd0;
        seq[c*16 + r*64 +: 16]   = 16'(r*4 + c + 1);
        k100[c*16 + r*64 +: 16]  = 16'h0100;
      end
    ma = {8{32'h0003_0002}};
    mb = {8{32'h0005_0007}};
    mc = {4{64'h0001_FFFF_0010_0002}};
    md = {16{16'h0009}};
    do_reset();

    // identity x 1..16
    issue(0, ident, seq);
    wait_gnt(0, 1);
    wait_done(LAT);
    check("identity_result", result, seq);
    tick();
    check("idle_busy", busy, 0);
    check("idle_enable", mm_enable, 0);

    // wrap: every element sums to 0x40000
    issue(0, k100, k100);
    wait_gnt(0, 1);
    wait_done(LAT);
    check("wrap_result", result, 0);

    // tie after reset: req0 first, then req1, then pointer swap
    do_reset();
    issue(0, ma, mb);
    issue(1, mc, md);
    wait_gnt(0, 1);
    wait_done(LAT);
    wait_gnt(1, 2);
    wait_done(LAT);
    tick();
    issue(0, mb, ma);
    wait_gnt(0, 1);
    wait_done(LAT);
    tick();
    issue(1, md, mc);
    issue(0, seq, seq);
    wait_gnt(1, 1);
    wait_done(LAT);
    wait_gnt(0, 2);
    wait_done(LAT);

    // req1 raised during req0's RUN
    tick();
    issue(0, seq, ma);
    wait_gnt(0, 1);
    issue(1, mc, seq);
    wait_done(LAT);
    wait_gnt(1, 2);
    wait_done(LAT);

    // reset at the second RUN cycle aborts the op
    tick();
    issue(0, mb, mc);
    wait_gnt(0, 1);
    tick();
    check("second_run_enable", mm_enable, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_enable", mm_enable, 0);
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_done", {done0, done1}, 0);
    void'(sb_who.pop_front());
    void'(sb_res.pop_front());
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_done_after_abort", {done0, done1}, 0);
    end
    issue(0, ident, md);
    issue(1, md, ident);
    wait_gnt(0, 1);
    wait_done(LAT);
    wait_gnt(1, 2);
    wait_done(LAT);

`ifdef MXU_CTRL_PERF_EN
    do_reset();
    check("perf_rst_ops", op_count, 0);
    check("perf_rst_busy", busy_cycles, 0);
    for (int i = 0; i < 3; i++) begin
      issue(0, seq, ma);
      wait_gnt(0, 1);
      wait_done(LAT);
      tick();
    end
    check("perf_op_count", op_count, 3);
    check("perf_busy_cycles", busy_cycles, 3 * (LAT + 1));
    force dut.r_op_count = 32'hFFFF_FFFF;
    tick();
    release dut.r_op_count;
    issue(0, mb, md);
    wait_gnt(0, 1);
    wait_done(LAT);
    tick();
    check("perf_op_count_sat", op_count, 32'hFFFF_FFFF);
    check("perf_busy_cycles_4", busy_cycles, 4 * (LAT + 1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
